oam_dma_arbiter: RTL and testbench
==================================

# oam_dma_arbiter

Shares the single CPU memory bus between the 6502 core and the sprite OAM DMA engine. A CPU write of page number V to $4014 halts the core and copies the 256 bytes at $VV00–$VVFF into OAMDATA ($2004), one read/write pair per byte. When idle, the block is a transparent pass-through between core and memory. It sits between `cpu` and the system memory/PPU address decoder.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA
- OAM_DATA_ADDR, 16'h2004, DMA write destination

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  16  core address
- cpu_d_out  in  8  core write data
- cpu_we  in  1  core write strobe
- cpu_rdy  out  1  high = core may advance; low = core holds all state and its bus
- mem_addr  out  16  shared bus address
- mem_d_out  out  8  shared bus write data
- mem_we  out  1  shared bus write strobe
- mem_d_in  in  8  shared bus read data, combinationally valid in the same cycle as mem_addr
- dma_active  out  1  high while any DMA state other than IDLE is active

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- `par` flop: reset value 0; toggles every clock.
- 8-bit page register `page`, 8-bit byte counter `cnt`, and 8-bit data latch `dlat`.
- IDLE: mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_we=cpu_we, cpu_rdy=1.
  - If cpu_we=1 and cpu_addr=DMA_REG_ADDR: the write still passes to the bus, page<=cpu_d_out, cnt<=0, and the next state is HALT.
- HALT: one dummy cycle with mem_we=0 and mem_addr=cpu_addr.
  - Next state is READ if par=1; otherwise ALIGN.
- ALIGN: one dummy cycle identical to HALT; next state is READ. READ therefore always occurs with par=0.
- READ: mem_addr={page,cnt}, mem_we=0, dlat<=mem_d_in; next state is WRITE.
- WRITE: mem_addr=OAM_DATA_ADDR, mem_d_out=dlat, mem_we=1, cnt<=cnt+1 (8-bit wrap).
  - If cnt=8'hFF before the increment, next state is IDLE; otherwise READ.
- In all non-IDLE states:
  - cpu_rdy=0 and dma_active=1.
  - cpu_we and cpu_d_out are ignored.
  - A $4014 write presented during DMA is discarded; it neither restarts nor queues a transfer.
- Page $FF is legal: the reads cover $FF00–$FFFF, and the 16-bit address never wraps because only the low byte counts.

## Timing
- Reset values: state=IDLE, par=0, cnt=0, page=0, dlat=0, cpu_rdy=1, dma_active=0. Bus outputs follow the cpu_* inputs.
- Reset asserted mid-transfer aborts immediately to reset values. No further OAM writes occur, and partial OAM contents are left as-is.
- cpu_rdy and dma_active are registered state decodes. They change on the clock edge that ends the trigger cycle and on the edge that ends the final WRITE.
- Total stall counted from the cycle after the trigger write:
  - 513 cycles if par=1 in HALT (HALT + 512).
  - 514 cycles if par=0 in HALT (HALT + ALIGN + 512).
- The first cycle after the final WRITE is IDLE, with the core owning the bus in that same cycle.
- Bus muxing is combinational from state. There is no extra latency between state and bus outputs.

## Structure
- Shared package `nes_pkg`:
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE).
  - Constants DMA_REG_ADDR_C=16'h4014 and OAM_DATA_ADDR_C=16'h2004, used as parameter defaults.
- Single module, no sub-module. The state register, counters, and bus mux are small enough to keep flat.

## Test plan
- Idle pass-through: cpu_addr=16'h1234, cpu_we=1, cpu_d_out=8'h5A -> mem_addr=16'h1234, mem_we=1, mem_d_out=8'h5A, cpu_rdy=1, dma_active=0.
- Even trigger: write 8'h02 to $4014 with par=1 in the trigger cycle -> HALT has par=0, ALIGN is inserted, and the stall lasts 514 cycles.
  - Reads hit $0200..$02FF, each followed by a write of the model byte to $2004.
  - 256 writes total, in order.
- Odd trigger: same transfer, but the trigger cycle has par=0 -> no ALIGN, stall is exactly 513 cycles, and the first READ occurs at cycle 2 with addr $0200.
- Page wrap: write 8'hFF to $4014 -> last read at $FFFF, then cnt wraps to 0 and the state is IDLE. No access to $0000 occurs.
- Ignored writes during DMA: the core drives cpu_we=1 with addr $4014 and data 8'h07 mid-transfer -> no bus write, page is unchanged, and no second transfer starts.
- Reset mid-transfer: assert rst after the 100th WRITE -> cpu_rdy=1 and dma_active=0 immediately, exactly 100 OAM writes are recorded, and the bus returns to pass-through.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES bus definitions: DMA state encoding and fixed register addresses.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_C  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU bus between the 6502 core and the sprite OAM DMA engine.
// A write to $4014 stalls the core and copies page $VV00-$VVFF into OAMDATA.
module oam_dma_arbiter
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_we,
    input  logic [7:0]  mem_d_in,
    output logic        dma_active
);

    dma_state_t state;
    logic       par;
    logic [7:0] page;
    logic [7:0] cnt;
    logic [7:0] dlat;

    // cpu_rdy/dma_active are registered alongside the state so they switch on
    // exactly the edges that enter and leave the transfer.
    // NOTE: every flop here uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            par        <= 1'b0;
            page       <= 8'h00;
            cnt        <= 8'h00;
            dlat       <= 8'h00;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
        end else begin
            par <= ~par;
            case (state)
                IDLE: begin
                    if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
                        page       <= cpu_d_out;
                        cnt        <= 8'h00;
                        state      <= HALT;
                        cpu_rdy    <= 1'b0;
                        dma_active <= 1'b1;
                    end
                end
                // Reads must land on even cycles; pad with ALIGN when needed.
                HALT:  state <= par ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    dlat  <= mem_d_in;
                    state <= WRITE;
                end
                WRITE: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'hFF) begin
                        state      <= IDLE;
                        cpu_rdy    <= 1'b1;
                        dma_active <= 1'b0;
                    end else begin
                        state <= READ;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cpu_rdy    <= 1'b1;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: pass-through defaults come first so no path through the case infers a latch.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_d_out = cpu_d_out;
        mem_we    = cpu_we;
        case (state)
            IDLE: ;
            HALT, ALIGN: begin
                mem_d_out = dlat;
                mem_we    = 1'b0;
            end
            READ: begin
                mem_addr  = {page, cnt};
                mem_d_out = dlat;
                mem_we    = 1'b0;
            end
            WRITE: begin
                mem_addr  = OAM_DATA_ADDR;
                mem_d_out = dlat;
                mem_we    = 1'b1;
            end
            default: mem_we = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized bench for oam_dma_arbiter against a cycle-indexed transfer model.
module tb_oam_dma_arbiter;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAM_REG = 16'h2004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_we;
    logic [7:0]  mem_d_in;
    logic        dma_active;

    logic [7:0]  mem_img [65536];
    bit          tb_par;
    int          n_tests = 0;
    int          n_fail  = 0;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_d_out  (cpu_d_out),
        .cpu_we     (cpu_we),
        .cpu_rdy    (cpu_rdy),
        .mem_addr   (mem_addr),
        .mem_d_out  (mem_d_out),
        .mem_we     (mem_we),
        .mem_d_in   (mem_d_in),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    assign mem_d_in = mem_img[mem_addr];

    // Parity model: cleared by reset, flips on every clock.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle_rand();
        cpu_addr  = 16'($urandom);
        cpu_d_out = 8'($urandom);
        cpu_we    = 1'($urandom);
        if (cpu_we && cpu_addr == DMA_REG) cpu_addr = 16'h4015;
    endtask

    task automatic check_pass(input string tag);
        check({tag, "_addr"}, mem_addr, cpu_addr);
        check({tag, "_data"}, mem_d_out, cpu_d_out);
        check({tag, "_we"}, mem_we, cpu_we);
        check({tag, "_rdy"}, cpu_rdy, 1);
        check({tag, "_active"}, dma_active, 0);
    endtask

    // One transfer of page pg, triggered in a cycle whose parity is want_par.
    // abort_at > 0 asserts reset right after that many OAM writes.
    task automatic run_dma(input logic [7:0] pg, input bit want_par, input bit poke, input int abort_at);
        int cyc;
        int lead;
        int writes;
        int k;
        bit done;
        cpu_we = 1'b0;
        step();
        if (tb_par != want_par) step();
        cpu_addr  = DMA_REG;
        cpu_we    = 1'b1;
        cpu_d_out = pg;
        @(negedge clk);
        check("trig_we", mem_we, 1);
        check("trig_addr", mem_addr, DMA_REG);
        check("trig_data", mem_d_out, pg);
        check("trig_rdy", cpu_rdy, 1);
        check("trig_active", dma_active, 0);

        lead   = want_par ? 2 : 1;
        cyc    = 0;
        writes = 0;
        done   = 1'b0;
        while (!done) begin
            step();
            cyc++;
            cpu_addr  = 16'($urandom);
            cpu_d_out = 8'($urandom);
            cpu_we    = 1'($urandom);
            if (poke && cyc == 200) begin
                cpu_addr  = DMA_REG;
                cpu_we    = 1'b1;
                cpu_d_out = 8'h07;
            end
            @(negedge clk);
            if (cpu_rdy) begin
                done = 1'b1;
            end else if (cyc > 600) begin
                check("stall_timeout", cyc, lead + 512);
                done = 1'b1;
            end else begin
                check("dma_active", dma_active, 1);
                k = cyc - lead - 1;
                if (k < 0) begin
                    check("dummy_we", mem_we, 0);
                    check("dummy_addr", mem_addr, cpu_addr);
                end else if (k % 2 == 0) begin
                    check("read_we", mem_we, 0);
                    check("read_addr", mem_addr, {pg, 8'(k / 2)});
                end else begin
                    check("write_we", mem_we, 1);
                    check("write_addr", mem_addr, OAM_REG);
                    check("write_data", mem_d_out, mem_img[{pg, 8'(k / 2)}]);
                    writes++;
                    if (abort_at > 0 && writes == abort_at) begin
                        rst = 1'b1;
                        #1;
                        check("abort_rdy", cpu_rdy, 1);
                        check("abort_active", dma_active, 0);
                        check("abort_addr", mem_addr, cpu_addr);
                        check("abort_we", mem_we, cpu_we);
                        check("abort_writes", writes, abort_at);
                        cpu_we = 1'b0;
                        @(posedge clk);
                        #1 rst = 1'b0;
                        for (int i = 0; i < 20; i++) begin
                            step();
                            drive_idle_rand();
                            @(negedge clk);
                            check_pass("post_abort");
                        end
                        return;
                    end
                end
            end
        end
        check("stall_len", cyc - 1, lead + 512);
        check("oam_writes", writes, 256);
        check("end_active", dma_active, 0);
        check("end_addr", mem_addr, cpu_addr);
        check("end_we", mem_we, cpu_we);
        for (int i = 0; i < 4; i++) begin
            step();
            drive_idle_rand();
            @(negedge clk);
            check_pass("after_dma");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_img[i] = 8'($urandom);
        cpu_addr  = 16'hBEEF;
        cpu_d_out = 8'h3C;
        cpu_we    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_pass("reset");
        rst = 1'b0;

        step();
        cpu_addr  = 16'h1234;
        cpu_we    = 1'b1;
        cpu_d_out = 8'h5A;
        @(negedge clk);
        check("pt_addr", mem_addr, 16'h1234);
        check("pt_we", mem_we, 1);
        check("pt_data", mem_d_out, 8'h5A);
        check("pt_rdy", cpu_rdy, 1);
        check("pt_active", dma_active, 0);

        for (int i = 0; i < 20; i++) begin
            step();
            drive_idle_rand();
            @(negedge clk);
            check_pass("idle");
        end

        run_dma(8'h02, 1'b1, 1'b0, 0);
        run_dma(8'h02, 1'b0, 1'b0, 0);
        run_dma(8'hFF, 1'($urandom), 1'b0, 0);
        run_dma(8'($urandom), 1'($urandom), 1'b1, 0);
        run_dma(8'($urandom), 1'($urandom), 1'b0, 100);
        run_dma(8'($urandom), 1'($urandom), 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
